// File: rtl/req_encoder_4to2_if.sv
// Request/grant bundle for the 4-line round-robin request encoder.
// The master side drives requests and the consumer handshake; the slave side returns the grant.
interface req_encoder_4to2_if;
   logic       en;
   logic [3:0] req;
   logic       ready;
   logic       valid;
   logic [1:0] code;
   logic       multi;
   logic [3:0] pend;

   modport master (
      output en,
      output req,
      output ready,
      input  valid,
      input  code,
      input  multi,
      input  pend
   );

   modport slave (
      input  en,
      input  req,
      input  ready,
      output valid,
      output code,
      output multi,
      output pend
   );
endinterface

// File: rtl/req_encoder_4to2.sv
// Round-robin 4-to-2 request encoder: requests latch into a sticky pending register and are
// granted one at a time from a registered IDLE/HOLD FSM, with a valid/ready handshake on the code.
module req_encoder_4to2 (
   input logic               clk,
   input logic               rst_n,
   req_encoder_4to2_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic       valid_q, valid_d;
   logic [1:0] code_q,  code_d;
   logic [1:0] last_q,  last_d;
   logic       multi_q, multi_d;
   logic [3:0] pend_q,  pend_d;
   logic [3:0] clr;

   // First set bit found searching upward from last+1, wrapping modulo 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
      logic [1:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && p[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] p);
      popcount4 = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
   endfunction

   always_comb begin
      clr = 4'b0000;
      if (valid_q && bus.ready) begin
         clr = 4'b0001 << code_q;
      end
      // A fresh request on the clearing edge survives because the OR is applied after the mask.
      pend_d  = (pend_q & ~clr) | (bus.en ? bus.req : 4'b0000);

      state_d = state_q;
      valid_d = valid_q;
      code_d  = code_q;
      multi_d = multi_q;
      last_d  = last_q;

      case (state_q)
         IDLE: begin
            if (bus.en && (pend_q != 4'b0000)) begin
               state_d = HOLD;
               valid_d = 1'b1;
               code_d  = rr_pick(pend_q, last_q);
               multi_d = (popcount4(pend_q) >= 3'd2);
            end
         end
         HOLD: begin
            // Enable does not gate completion: an accepted grant always retires.
            if (bus.ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
               last_d  = code_q;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         code_q  <= 2'b00;
         multi_q <= 1'b0;
         pend_q  <= 4'b0000;
         last_q  <= 2'b11;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         multi_q <= multi_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
      end
   end

   assign bus.valid = valid_q;
   assign bus.code  = code_q;
   assign bus.multi = multi_q;
   assign bus.pend  = pend_q;

endmodule
